// File: rtl/udc_updown_counter.sv
// WIDTH-bit synchronous up/down counter with clear, preset, parallel load, wrap/saturate,
// terminal-count pulse and sticky overflow. Define UDC_MODULO_EN to cap the count at MOD_MAX.
module udc_updown_counter #(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE   = 1'b0,
  parameter longint unsigned MOD_MAX    = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_in,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q_out,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("udc_updown_counter: WIDTH must be in 2..32");
  end

`ifdef UDC_MODULO_EN
  localparam bit MOD_EN = 1'b1;
  if (MOD_MAX > MAX_VAL || MOD_MAX < 64'd1) begin : g_bad_mod_max
    $error("udc_updown_counter: MOD_MAX must be in 1..2**WIDTH-1");
  end
`else
  localparam bit MOD_EN = 1'b0;
`endif

  // Upper count limit; the lower limit is always zero.
  localparam logic [WIDTH-1:0] LIM = WIDTH'(MOD_EN ? MOD_MAX : MAX_VAL);

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  // Next-state selection in priority order; out-of-range values (>= LIM) treat an up step as a boundary.
  always_comb begin
    q_nxt   = q_out;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    if (clear_in) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (preset) begin
      q_nxt = PRESET_VAL;
    end else if (load) begin
      q_nxt = din;
    end else if (enable) begin
      if (up_dn) begin
        if (q_out >= LIM) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? q_out : '0;
        end else begin
          q_nxt = q_out + WIDTH'(1);
        end
      end else begin
        if (q_out == '0) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          q_nxt   = SATURATE ? '0 : LIM;
        end else begin
          q_nxt = q_out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_out <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      q_out <= q_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign zero = (q_out == '0);

endmodule

// File: tb/tb_udc_updown_counter.sv
// Self-checking bench for udc_updown_counter: a wrapping and a saturating instance share
// stimulus and are compared against an arithmetic reference model after every edge.
module tb_udc_updown_counter;

  localparam int unsigned W       = 8;
  localparam int unsigned MOD_MAX = 9;
  localparam int unsigned PRESET  = 255;
`ifdef UDC_MODULO_EN
  localparam int unsigned LIM = MOD_MAX;
`else
  localparam int unsigned LIM = 255;
`endif

  logic         clk = 1'b0;
  logic         rst, clear_in, preset, load, enable, up_dn;
  logic [W-1:0] din;
  logic [W-1:0] q_w, q_s;
  logic         tc_w, tc_s, ovf_w, ovf_s, zero_w, zero_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: index 0 = wrapping instance, 1 = saturating instance.
  int m_q[2];
  int m_tc[2];
  int m_ovf[2];

  always #5 clk = ~clk;

  udc_updown_counter #(.WIDTH(W), .SATURATE(1'b0), .MOD_MAX(MOD_MAX)) u_wrap (
    .clk(clk), .rst(rst), .clear_in(clear_in), .preset(preset), .load(load), .din(din),
    .enable(enable), .up_dn(up_dn), .q_out(q_w), .tc(tc_w), .ovf(ovf_w), .zero(zero_w)
  );

  udc_updown_counter #(.WIDTH(W), .SATURATE(1'b1), .MOD_MAX(MOD_MAX)) u_sat (
    .clk(clk), .rst(rst), .clear_in(clear_in), .preset(preset), .load(load), .din(din),
    .enable(enable), .up_dn(up_dn), .q_out(q_s), .tc(tc_s), .ovf(ovf_s), .zero(zero_s)
  );

  task automatic model_step(input int i, input bit sat);
    m_tc[i] = 0;
    if (rst || clear_in) begin
      m_q[i]   = 0;
      m_ovf[i] = 0;
    end else if (preset) begin
      m_q[i] = PRESET;
    end else if (load) begin
      m_q[i] = int'(din);
    end else if (enable && up_dn) begin
      if (m_q[i] >= int'(LIM)) begin
        m_tc[i]  = 1;
        m_ovf[i] = 1;
        if (!sat) m_q[i] = 0;
      end else begin
        m_q[i] = m_q[i] + 1;
      end
    end else if (enable) begin
      if (m_q[i] == 0) begin
        m_tc[i]  = 1;
        m_ovf[i] = 1;
        m_q[i]   = sat ? 0 : int'(LIM);
      end else begin
        m_q[i] = m_q[i] - 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [W-1:0] eq0, eq1;
    eq0 = W'(m_q[0]);
    eq1 = W'(m_q[1]);
    n_cmp++;
    assert (q_w === eq0) else begin
      n_fail++; $error("FAIL %s q_wrap observed=%0h expected=%0h", tag, q_w, eq0);
    end
    n_cmp++;
    assert (tc_w === 1'(m_tc[0])) else begin
      n_fail++; $error("FAIL %s tc_wrap observed=%0b expected=%0d", tag, tc_w, m_tc[0]);
    end
    n_cmp++;
    assert (ovf_w === 1'(m_ovf[0])) else begin
      n_fail++; $error("FAIL %s ovf_wrap observed=%0b expected=%0d", tag, ovf_w, m_ovf[0]);
    end
    n_cmp++;
    assert (zero_w === (m_q[0] == 0)) else begin
      n_fail++; $error("FAIL %s zero_wrap observed=%0b expected=%0b", tag, zero_w, m_q[0] == 0);
    end
    n_cmp++;
    assert (q_s === eq1) else begin
      n_fail++; $error("FAIL %s q_sat observed=%0h expected=%0h", tag, q_s, eq1);
    end
    n_cmp++;
    assert (tc_s === 1'(m_tc[1])) else begin
      n_fail++; $error("FAIL %s tc_sat observed=%0b expected=%0d", tag, tc_s, m_tc[1]);
    end
    n_cmp++;
    assert (ovf_s === 1'(m_ovf[1])) else begin
      n_fail++; $error("FAIL %s ovf_sat observed=%0b expected=%0d", tag, ovf_s, m_ovf[1]);
    end
    n_cmp++;
    assert (zero_s === (m_q[1] == 0)) else begin
      n_fail++; $error("FAIL %s zero_sat observed=%0b expected=%0b", tag, zero_s, m_q[1] == 0);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit p, input bit l,
                       input logic [W-1:0] d, input bit e, input bit u);
    rst = r; clear_in = c; preset = p; load = l; din = d; enable = e; up_dn = u;
  endtask

  // One rising edge: advance the model on the sampled inputs, then check 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check(tag);
  endtask

  initial begin
    m_q   = '{0, 0};
    m_tc  = '{0, 0};
    m_ovf = '{0, 0};
    drive(1, 0, 0, 0, '0, 1, 1);
    tick("reset0");
    tick("reset1");
    n_cmp++;
    assert (q_w === 8'h00 && zero_w === 1'b1) else begin
      n_fail++; $error("FAIL reset_const observed=%0h/%0b expected=00/1", q_w, zero_w);
    end

    drive(0, 0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 3; i++) tick("count_up");
    n_cmp++;
    assert (q_w === 8'h03) else begin
      n_fail++; $error("FAIL after_reset_count observed=%0h expected=03", q_w);
    end

    drive(0, 0, 0, 1, 8'hFE, 0, 1);
    tick("load_fe");
    drive(0, 0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 7; i++) tick("up_wrap");

    drive(0, 1, 0, 0, '0, 0, 1);
    tick("clear");
    drive(0, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) tick("down_sat");
    drive(0, 0, 0, 0, '0, 1, 1);
    tick("up_after_sat");

    drive(0, 1, 1, 1, 8'h5A, 1, 1);
    tick("prio_clear");
    drive(0, 0, 1, 1, 8'h5A, 1, 1);
    tick("prio_preset");
    drive(0, 0, 0, 1, 8'h5A, 1, 1);
    tick("prio_load");

    drive(0, 0, 0, 1, 8'h33, 0, 1);
    tick("load_33");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, '0, 0, 1'(i));
      tick("hold");
    end

    drive(0, 1, 0, 0, '0, 0, 1);
    tick("clear2");
    drive(0, 0, 0, 0, '0, 1, 1);
    for (int i = 0; i < 11; i++) tick("up_run");
    drive(0, 1, 0, 0, '0, 0, 1);
    tick("clear3");
    drive(0, 0, 0, 0, '0, 1, 0);
    tick("down_from_zero");

    // Randomized phase with biased loads near the count limits.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] d;
      int pick;
      pick = int'($urandom_range(0, 3));
      case (pick)
        0: d = W'(LIM);
        1: d = W'(LIM - 1);
        2: d = W'(1);
        default: d = W'($urandom);
      endcase
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 8, d, $urandom_range(0, 99) < 75, 1'($urandom));
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
